// File: rtl/ins_issuer_if.sv
// Command handshake between a producer and the instruction issuer.
interface ins_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [11:0] cmd_address;

  modport master (output cmd_valid, cmd_opcode, cmd_address, input cmd_ready);
  modport slave  (input cmd_valid, cmd_opcode, cmd_address, output cmd_ready);
endinterface

// File: rtl/ins_issuer.sv
// Instruction issuer: buffers {opcode, address} commands in a small FIFO and
// drives them onto insin with a one-cycle loadIR strobe, spacing strobes by
// GAP idle cycles.
module ins_issuer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ins_issuer_if.slave            cmd,
  output logic [15:0]            insin,
  output logic                   loadIR,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      gap_cnt;
  logic            full, empty, push, pop;
  logic [15:0]     head;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign head          = mem[rd_ptr];
  assign busy          = !empty || (state != IDLE);

  // Pop whenever the FSM is about to raise or keep loadIR. An expiring HOLD
  // issues directly so the steady-state pulse period is exactly GAP+1.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      ISSUE:   pop = (GAP == 0) && !empty;
      HOLD:    pop = (gap_cnt == 4'd0) && !empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset, pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_opcode, cmd.cmd_address};
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered insin/loadIR; insin only moves when loadIR is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      insin   <= 16'h0000;
      loadIR  <= 1'b0;
      gap_cnt <= 4'd0;
    end else begin
      loadIR <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            insin  <= head;
            loadIR <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (GAP == 0) begin
            if (pop) begin
              insin  <= head;
              loadIR <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= GAP_LD;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (gap_cnt == 4'd0) begin
            if (pop) begin
              insin  <= head;
              loadIR <= 1'b1;
              state  <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_issuer.sv
// Directed bench for ins_issuer: three instances cover GAP=1, GAP=3 and GAP=0.
module tb_ins_issuer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_issuer_if c1 ();
  ins_issuer_if c3 ();
  ins_issuer_if c0 ();

  logic [15:0] insin1, insin3, insin0;
  logic        ld1, ld3, ld0;
  logic [2:0]  cnt1, cnt3, cnt0;
  logic        busy1, busy3, busy0;

  ins_issuer #(.DEPTH(4), .GAP(1)) u1 (.clk(clk), .rst(rst), .cmd(c1), .insin(insin1),
    .loadIR(ld1), .count(cnt1), .busy(busy1));
  ins_issuer #(.DEPTH(4), .GAP(3)) u3 (.clk(clk), .rst(rst), .cmd(c3), .insin(insin3),
    .loadIR(ld3), .count(cnt3), .busy(busy3));
  ins_issuer #(.DEPTH(4), .GAP(0)) u0 (.clk(clk), .rst(rst), .cmd(c0), .insin(insin0),
    .loadIR(ld0), .count(cnt0), .busy(busy0));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // edge counter: at the negedge after edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // pulse recorders: edge index and word of every cycle with loadIR high
  int          q1c[$], q3c[$], q0c[$];
  logic [15:0] q1w[$], q3w[$], q0w[$];
  int          max3 = 0;
  bit          nr3 = 0;
  always @(negedge clk) begin
    if (ld1) begin q1c.push_back(cyc); q1w.push_back(insin1); end
    if (ld3) begin q3c.push_back(cyc); q3w.push_back(insin3); end
    if (ld0) begin q0c.push_back(cyc); q0w.push_back(insin0); end
    if (int'(cnt3) > max3) max3 = int'(cnt3);
    if (!c3.cmd_ready) nr3 = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_insin"}, 32'(insin3), 32'h0);
    chk({tag, "_ld"},    32'(ld3),    32'h0);
    chk({tag, "_rdy"},   32'(c3.cmd_ready), 32'h1);
    chk({tag, "_cnt"},   32'(cnt3),   32'h0);
    chk({tag, "_busy"},  32'(busy3),  32'h0);
  endtask

  logic [15:0] w3 [3]  = '{16'hB0F0, 16'h50AA, 16'hF00F};
  logic [15:0] w6 [6]  = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 16'hF006};
  logic [15:0] w4 [4]  = '{16'h3123, 16'h4234, 16'h5345, 16'h6456};
  logic [15:0] wr2 [3] = '{16'h1AAA, 16'h2BBB, 16'h3CCC};
  int n;

  initial begin
    // reset held 2 cycles with valid asserted everywhere
    rst = 1'b1;
    c1.cmd_valid = 1'b1; {c1.cmd_opcode, c1.cmd_address} = 16'h9999;
    c3.cmd_valid = 1'b1; {c3.cmd_opcode, c3.cmd_address} = 16'h8888;
    c0.cmd_valid = 1'b1; {c0.cmd_opcode, c0.cmd_address} = 16'h7777;
    tick(); tick();
    chk_rst("rst");
    chk("rst_cnt1", 32'(cnt1), 32'h0);
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    rst = 1'b0;
    c1.cmd_valid = 1'b0; c3.cmd_valid = 1'b0; c0.cmd_valid = 1'b0;
    repeat (4) tick();
    chk("rst_noacc", 32'(q1c.size() + q3c.size() + q0c.size()), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);

    // single command on GAP=1
    q1c.delete(); q1w.delete();
    n = cyc + 1;
    c1.cmd_valid = 1'b1; c1.cmd_opcode = 4'b1011; c1.cmd_address = 12'h0F0;
    tick();
    c1.cmd_valid = 1'b0;
    repeat (6) tick();
    chk("one_npulse", 32'(q1c.size()), 32'h1);
    if (q1c.size() > 0) begin
      chk("one_cyc", 32'(q1c[0]), 32'(n + 1));
      chk("one_word", 32'(q1w[0]), 32'hB0F0);
    end
    chk("one_op", 32'(insin1[15:12]), 32'hB);
    chk("one_addr", 32'(insin1[11:0]), 32'h0F0);
    chk("one_busy", 32'(busy1), 32'h0);

    // three back-to-back pushes on GAP=1
    q1c.delete(); q1w.delete();
    n = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      c1.cmd_valid = 1'b1; {c1.cmd_opcode, c1.cmd_address} = w3[k];
      tick();
    end
    c1.cmd_valid = 1'b0;
    repeat (10) tick();
    chk("b2b_npulse", 32'(q1c.size()), 32'h3);
    for (int k = 0; k < 3; k++) if (k < q1c.size()) begin
      chk($sformatf("b2b_cyc%0d", k), 32'(q1c[k]), 32'(n + 1 + 2 * k));
      chk($sformatf("b2b_word%0d", k), 32'(q1w[k]), 32'(w3[k]));
    end

    // fill on GAP=3 with valid held high, 6 words
    q3c.delete(); q3w.delete(); max3 = 0; nr3 = 0;
    n = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      int g = 0;
      c3.cmd_valid = 1'b1; {c3.cmd_opcode, c3.cmd_address} = w6[k];
      while (!c3.cmd_ready && g < 50) begin tick(); g++; end
      if (g >= 50) chk("fill_acc_timeout", 32'(g), 32'h0);
      tick();
    end
    c3.cmd_valid = 1'b0;
    repeat (30) tick();
    chk("fill_nr", 32'(nr3), 32'h1);
    chk("fill_max", 32'(max3), 32'h4);
    chk("fill_npulse", 32'(q3c.size()), 32'h6);
    for (int k = 0; k < 6; k++) if (k < q3c.size()) begin
      chk($sformatf("fill_cyc%0d", k), 32'(q3c[k]), 32'(n + 1 + 4 * k));
      chk($sformatf("fill_word%0d", k), 32'(q3w[k]), 32'(w6[k]));
    end
    chk("fill_busy", 32'(busy3), 32'h0);

    // GAP=0 burst of 4
    q0c.delete(); q0w.delete();
    n = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      c0.cmd_valid = 1'b1; {c0.cmd_opcode, c0.cmd_address} = w4[k];
      tick();
    end
    c0.cmd_valid = 1'b0;
    while (cyc < n + 5) tick();
    chk("g0_ld_end", 32'(ld0), 32'h0);
    chk("g0_busy_end", 32'(busy0), 32'h0);
    repeat (3) tick();
    chk("g0_npulse", 32'(q0c.size()), 32'h4);
    for (int k = 0; k < 4; k++) if (k < q0c.size()) begin
      chk($sformatf("g0_cyc%0d", k), 32'(q0c[k]), 32'(n + 1 + k));
      chk($sformatf("g0_word%0d", k), 32'(q0w[k]), 32'(w4[k]));
    end

    // reset in HOLD on GAP=3 with 2 words still queued
    q3c.delete(); q3w.delete();
    for (int k = 0; k < 3; k++) begin
      c3.cmd_valid = 1'b1; {c3.cmd_opcode, c3.cmd_address} = wr2[k];
      tick();
    end
    c3.cmd_valid = 1'b0;
    chk("hold_cnt", 32'(cnt3), 32'h2);
    chk("hold_ld", 32'(ld3), 32'h0);
    rst = 1'b1;
    tick();
    chk_rst("hrst");
    rst = 1'b0;
    repeat (15) tick();
    chk("hrst_npulse", 32'(q3c.size()), 32'h1);
    chk("hrst_busy", 32'(busy3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
